// File: rtl/mem_stage.sv
// Y86-64 memory stage: M pipeline register plus byte-banked data memory.
// Loads are combinational; stores commit at the clock edge that ends the store's M cycle.

module mem_bank #(
  parameter int ROWS = 128,
  parameter int RW   = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [RW-1:0] row,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [ROWS];

  always_ff @(posedge clk)
    if (we) mem[row] <= wdata;

  assign rdata = mem[row];
endmodule

module mem_stage #(
  parameter int         DMEM_BYTES = 1024,
  parameter logic [3:0] AOK        = 4'b1000,
  parameter logic [3:0] HLT        = 4'b0100,
  parameter logic [3:0] ADR        = 4'b0010,
  parameter logic [3:0] INS        = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        M_bubble,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic        mem_error
);
  localparam int NUM_LANES = 8;
  localparam int ROWS      = DMEM_BYTES / NUM_LANES;
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (AOK == HLT || AOK == ADR || AOK == INS ||
      HLT == ADR || HLT == INS || ADR == INS) begin : g_stat_check
    $error("mem_stage: status codes must be distinct");
  end

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } mreg_t;

  localparam mreg_t BUBBLE = '{stat: AOK, icode: 4'h1, cnd: 1'b0,
                               valE: 64'd0, valA: 64'd0,
                               dstE: 4'hF, dstM: 4'hF};

  mreg_t m_q;

  always_ff @(posedge clk) begin
    if (rst || M_bubble)
      m_q <= BUBBLE;
    else
      m_q <= '{stat: e_stat, icode: e_icode, cnd: e_Cnd, valE: e_valE,
               valA: e_valA, dstE: e_dstE, dstM: e_dstM};
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.valE;
  assign M_valA  = m_q.valA;
  assign M_dstE  = m_q.dstE;
  assign M_dstM  = m_q.dstM;

  logic        rd_en, wr_en, do_store;
  logic [63:0] addr;
  logic [2:0]  off;
  logic [RW-1:0] base_row;

  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    unique case (m_q.icode)
      4'h5, 4'h9, 4'hB: rd_en = 1'b1;
      4'h4, 4'h8, 4'hA: wr_en = 1'b1;
      default: ;
    endcase
  end

  assign addr      = (m_q.icode == 4'h9 || m_q.icode == 4'hB) ? m_q.valA : m_q.valE;
  // Unsigned compare catches negative and wrapped addresses in one test.
  assign mem_error = (rd_en || wr_en) && (addr > 64'(DMEM_BYTES - 8));
  assign do_store  = wr_en && !mem_error && (m_q.stat == AOK) && !rst;
  assign off       = addr[2:0];
  assign base_row  = addr[RW+2:3];

  logic [NUM_LANES-1:0][7:0] wbytes, bank_rd, rbytes;
  assign wbytes = m_q.valA;

  // Byte (addr + j) lives in bank (off + j) % 8; banks below off spill into the next row.
  for (genvar b = 0; b < NUM_LANES; b++) begin : g_bank
    logic [RW-1:0] row;
    logic [2:0]    lane;
    assign row  = base_row + RW'(3'(b) < off);
    assign lane = 3'(b) - off;
    mem_bank #(.ROWS(ROWS), .RW(RW)) u_bank (
      .clk  (clk),
      .we   (do_store),
      .row  (row),
      .wdata(wbytes[lane]),
      .rdata(bank_rd[b])
    );
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_rot
    assign rbytes[j] = bank_rd[3'(j) + off];
  end

  assign m_valM = (rd_en && !mem_error) ? rbytes : 64'd0;
  assign m_stat = mem_error ? ADR : m_q.stat;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-array reference model predicts every cycle.
module tb_mem_stage;
  localparam int DMEM = 1024;
  localparam logic [3:0] AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010, INS = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1, M_bubble = 1'b0, e_Cnd = 1'b0;
  logic [3:0]  e_stat = AOK, e_icode = 4'h1, e_dstE = 4'hF, e_dstM = 4'hF;
  logic [63:0] e_valE = '0, e_valA = '0;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM, m_stat;
  logic        M_Cnd, mem_error;
  logic [63:0] M_valE, M_valA, m_valM;

  mem_stage #(.DMEM_BYTES(DMEM)) dut (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_bubble(M_bubble), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_valM(m_valM), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat, icode;
    logic        cnd;
    logic [63:0] valE, valA;
    logic [3:0]  dstE, dstM;
  } mr_t;

  typedef struct {
    mr_t         m;
    logic [3:0]  mstat;
    logic [63:0] valM;
    logic        err;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  mr_t        mm;
  logic [7:0] ref_mem [DMEM];
  int         n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mr_t bubble_m();
    mr_t m;
    m.stat = AOK; m.icode = 4'h1; m.cnd = 1'b0; m.valE = '0; m.valA = '0;
    m.dstE = 4'hF; m.dstM = 4'hF;
    return m;
  endfunction

  function automatic logic [63:0] addr_of(input mr_t m);
    return (m.icode == 4'h9 || m.icode == 4'hB) ? m.valA : m.valE;
  endfunction

  function automatic exp_t predict(input mr_t m);
    exp_t        e;
    logic        rd, wr;
    logic [63:0] a, w;
    rd = (m.icode == 4'h5 || m.icode == 4'h9 || m.icode == 4'hB);
    wr = (m.icode == 4'h4 || m.icode == 4'h8 || m.icode == 4'hA);
    a  = addr_of(m);
    w  = '0;
    e.m   = m;
    e.err = (rd || wr) && !(a <= 64'(DMEM - 8));
    if (rd && !e.err)
      for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mem[int'(a) + i];
    e.valM  = w;
    e.mstat = e.err ? ADR : m.stat;
    return e;
  endfunction

  // Drive one cycle, advance the model across the edge, queue the post-edge prediction.
  task automatic cyc(input logic r, b, input logic [3:0] st, ic, input logic c,
                     input logic [63:0] vE, vA, input logic [3:0] dE, dM);
    exp_t        cur;
    logic [63:0] a;
    @(negedge clk);
    rst = r; M_bubble = b; e_stat = st; e_icode = ic; e_Cnd = c;
    e_valE = vE; e_valA = vA; e_dstE = dE; e_dstM = dM;
    cur = predict(mm);
    a   = addr_of(mm);
    if (!r && !cur.err && mm.stat == AOK &&
        (mm.icode == 4'h4 || mm.icode == 4'h8 || mm.icode == 4'hA))
      for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = mm.valA[8*i +: 8];
    if (r || b) mm = bubble_m();
    else begin
      mm.stat = st; mm.icode = ic; mm.cnd = c; mm.valE = vE; mm.valA = vA;
      mm.dstE = dE; mm.dstM = dM;
    end
    q.push_back(predict(mm));
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [3:0] ic, input logic [63:0] vE, vA,
                    input logic [3:0] dM = 4'hF);
    cyc(1'b0, 1'b0, AOK, ic, 1'b0, vE, vA, 4'hF, dM);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("M_stat",    M_stat,    mon_e.m.stat);
      chk("M_icode",   M_icode,   mon_e.m.icode);
      chk("M_Cnd",     M_Cnd,     mon_e.m.cnd);
      chk("M_valE",    M_valE,    mon_e.m.valE);
      chk("M_valA",    M_valA,    mon_e.m.valA);
      chk("M_dstE",    M_dstE,    mon_e.m.dstE);
      chk("M_dstM",    M_dstM,    mon_e.m.dstM);
      chk("m_stat",    m_stat,    mon_e.mstat);
      chk("m_valM",    m_valM,    mon_e.valM);
      chk("mem_error", mem_error, mon_e.err);
    end
  end

  initial begin
    logic [63:0] ra;
    logic [3:0]  rs;
    mm = bubble_m();
    for (int i = 0; i < DMEM; i++) ref_mem[i] = 8'h00;

    cyc(1'b1, 1'b0, AOK, 4'h4, 1'b1, 64'h8, 64'h55, 4'h2, 4'h3);
    cyc(1'b1, 1'b1, INS, 4'h5, 1'b1, 64'h8, 64'h55, 4'h2, 4'h3);
    chk("rst_icode", M_icode, 4'h1);
    chk("rst_stat", M_stat, AOK);
    chk("rst_dstE", M_dstE, 4'hF);
    chk("rst_dstM", M_dstM, 4'hF);
    chk("rst_valM", m_valM, 64'd0);
    chk("rst_err", mem_error, 1'b0);

    for (int k = 0; k < DMEM / 8; k++) op(4'h4, 64'(8 * k), {$urandom, $urandom});
    op(4'h1, 64'd0, 64'd0);

    op(4'h4, 64'h10, 64'h1122334455667788);
    op(4'h5, 64'h10, 64'd0, 4'h3);
    chk("ld_valM", m_valM, 64'h1122334455667788);
    chk("ld_dstM", M_dstM, 4'h3);
    chk("ld_stat", m_stat, AOK);
    chk("ld_byte10", m_valM[7:0], 8'h88);

    op(4'hA, 64'h1F8, 64'hABCD);
    op(4'hB, 64'h0, 64'h1F8);
    chk("pop_valM", m_valM, 64'hABCD);
    op(4'h8, 64'h1F0, 64'h40);
    op(4'h9, 64'h0, 64'h1F0);
    chk("ret_valM", m_valM, 64'h40);

    op(4'h5, 64'h3F9, 64'd0);
    chk("flt_err", mem_error, 1'b1);
    chk("flt_stat", m_stat, ADR);
    chk("flt_valM", m_valM, 64'd0);
    op(4'h4, 64'h3F8, 64'h5A5A_0102_0304_A5A5);
    op(4'h5, 64'h3F8, 64'd0);
    chk("edge_err", mem_error, 1'b0);
    chk("edge_valM", m_valM, 64'h5A5A_0102_0304_A5A5);

    op(4'h4, 64'h0, 64'h0F0E_0D0C_0B0A_0908);
    op(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD);
    chk("neg_err", mem_error, 1'b1);
    op(4'h5, 64'h0, 64'd0);
    chk("neg_ld0", m_valM, 64'h0F0E_0D0C_0B0A_0908);
    op(4'h5, 64'h3F8, 64'd0);
    chk("neg_ld3f8", m_valM, 64'h5A5A_0102_0304_A5A5);

    op(4'h4, 64'h30, 64'h3030);
    cyc(1'b0, 1'b1, AOK, 4'h4, 1'b0, 64'h30, 64'hBAD, 4'hF, 4'hF);
    chk("bub_icode", M_icode, 4'h1);
    op(4'h5, 64'h30, 64'd0);
    chk("bub_mem", m_valM, 64'h3030);
    cyc(1'b0, 1'b0, INS, 4'h4, 1'b0, 64'h30, 64'hBAD, 4'hF, 4'hF);
    chk("ins_stat", m_stat, INS);
    op(4'h5, 64'h30, 64'd0);
    chk("ins_mem", m_valM, 64'h3030);
    op(4'h4, 64'h30, 64'hBEEF);
    cyc(1'b1, 1'b0, AOK, 4'h5, 1'b0, 64'h30, 64'd0, 4'hF, 4'hF);
    chk("rstdrop_icode", M_icode, 4'h1);
    op(4'h5, 64'h30, 64'd0);
    chk("rstdrop_mem", m_valM, 64'h3030);

    op(4'h4, 64'h18, 64'h0123_4567_89AB_CDEF);
    op(4'h4, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    op(4'h4, 64'h24, 64'h0);
    op(4'h5, 64'h20, 64'd0);
    chk("merge_20", m_valM, 64'h0000_0000_FFFF_FFFF);
    op(4'h5, 64'h1C, 64'd0);
    chk("merge_1c", m_valM, 64'hFFFF_FFFF_0123_4567);

    cyc(1'b0, 1'b0, HLT, 4'h6, 1'b1, '1, '1, 4'h2, 4'hF);
    chk("nop_err", mem_error, 1'b0);
    chk("nop_stat", m_stat, HLT);
    chk("nop_valM", m_valM, 64'd0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(3))
        0, 1:    ra = 64'($urandom_range(DMEM - 1));
        2:       ra = 64'(DMEM - 16 + $urandom_range(15));
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(5))
        0:       rs = HLT;
        1:       rs = INS;
        default: rs = AOK;
      endcase
      cyc($urandom_range(39) == 0, $urandom_range(9) == 0, rs, 4'($urandom_range(15)),
          1'($urandom_range(1)), ra, $urandom_range(1) ? ra : {$urandom, $urandom},
          4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    op(4'h1, 64'd0, 64'd0);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipelined Y86-64 core; the consuming end of the execute-stage outputs (e_*).
- Holds the M pipeline register and latches e_stat/e_icode/e_Cnd/e_valE/e_valA/e_dstE/e_dstM each cycle, or injects a bubble.
- Performs the data-memory access for the held instruction and produces m_stat/m_valM.
- Exports M-register fields for forwarding and hazard control, and feeds the W register.

Parameters:
- DMEM_BYTES, 1024, data memory size in bytes (multiple of 8).
- AOK, 4'b1000, status: normal.
- HLT, 4'b0100, status: halt.
- ADR, 4'b0010, status: bad address.
- INS, 4'b0001, status: illegal instruction.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- e_stat  in  4  execute status.
- e_icode  in  4  execute icode.
- e_Cnd  in  1  condition result.
- e_valE  in  64  ALU result.
- e_valA  in  64  store data / valP / pop-ret address.
- e_dstE  in  4  destination register for valE (15 = none).
- e_dstM  in  4  destination register for valM (15 = none).
- M_bubble  in  1  load bubble into M instead of e_* at this edge.
- M_stat, M_icode  out  4 each  registered.
- M_Cnd  out  1  registered.
- M_valE, M_valA  out  64 each  registered.
- M_dstE, M_dstM  out  4 each  registered.
- m_stat  out  4  combinational memory-stage status.
- m_valM  out  64  combinational load data.
- mem_error  out  1  combinational address fault.

Behaviour:
- Reset (rst=1 at posedge) loads the bubble value: M_stat=AOK, M_icode=4'h1 (nop), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=15, M_dstM=15.
- Memory contents are not cleared by reset.
- Reset dominates M_bubble.
- Asserting reset mid-operation cancels any store held in M: no write occurs at the reset edge.
- At each posedge with rst=0:
  - M_bubble=1: load the bubble value.
  - Otherwise: copy e_* into M_* (one-cycle latency).
  - There is no stall input; M always advances.
- Read enable (combinational from M_icode): 5 mrmovq, 9 ret, 11 popq.
- Write enable: 4 rmmovq, 8 call, 10 pushq.
- Address: M_valA for icode 9 and 11; M_valE for all others.
- Address fault:
  - mem_error=1 iff (read or write enabled) and the unsigned address > DMEM_BYTES-8.
  - Covers wrap and negative addresses, e.g. 0xFFFFFFFFFFFFFFF8.
  - Addresses need not be 8-aligned.
- Word format: 8 bytes, little-endian (byte at addr = bits 7:0).
- Load: asynchronous/combinational. m_valM = word at address when read enabled and no fault; otherwise 0.
- Store:
  - Writes M_valA at the posedge ending the cycle in which the store sits in M.
  - Performed only if write enabled, mem_error=0, M_stat=AOK, and rst=0.
  - A load in the next cycle to an overlapping address returns the new bytes. Partial overlaps are merged bytewise.
- m_stat = ADR if mem_error=1; otherwise M_stat.
- A bubble has icode 1, so it never reads, writes, or faults.
- Other icodes (0, 1, 2, 3, 6, 7, and 12–15) perform no access.
  - m_valM=0, mem_error=0, m_stat=M_stat.

Test Plan:
- Reset: assert rst for 2 cycles, then release. Required: M_icode=1, M_stat=1000, M_dstE=M_dstM=15, m_valM=0, mem_error=0.
- Store then load:
  - Cycle 1: e_icode=4, e_valE=0x10, e_valA=0x1122334455667788.
  - Cycle 2: e_icode=5, e_valE=0x10, e_dstM=3.
  - Required: load cycle shows m_valM=0x1122334455667788, M_dstM=3, m_stat=1000.
  - Byte 0x10 = 0x88 (checked via a load at 0x10).
- Stack ops: e_icode=10, e_valE=0x1F8, e_valA=0xABCD, followed by e_icode=11, e_valA=0x1F8. Required: pop cycle m_valM=0xABCD. Repeat with call(8)/ret(9), valA=0x40 → ret m_valM=0x40.
- Fault:
  - Case 1: e_icode=5, e_valE=DMEM_BYTES-7 (0x3F9). Required: mem_error=1, m_stat=0010, m_valM=0.
  - Case 2: e_icode=4, e_valE=0xFFFFFFFFFFFFFFF8, e_valA=0xDEAD. Required: mem_error=1, no memory write; a subsequent load of 0x0 is unchanged.
- Bubble/status gating:
  - Store with M_bubble=1 → M_icode=1, and a later load shows memory unchanged.
  - Store with e_stat=INS → not written, m_stat=0001.
  - rst=1 on the edge ending a store's M cycle → store dropped.
- Misaligned merge: store 0xFFFFFFFFFFFFFFFF at 0x20, then store 0x0 at 0x24. Required: load at 0x20 gives 0x00000000FFFFFFFF; load at 0x1C gives 0xFFFFFFFF00000000 upper bytes from 0x20..0x23 with lower bytes prior contents.
